// File: rtl/uart_rx_sampler_if.sv
// Serial-line and received-byte signals between the UART receive front end and its consumer.
interface uart_rx_sampler_if;
    logic       rxd;
    logic [7:0] data;
    logic       rxdDataReady;
    logic       frameError;
    logic       parityError;
    logic       busy;

    modport master (
        input  rxd,
        output data, rxdDataReady, frameError, parityError, busy
    );

    modport slave (
        output rxd,
        input  data, rxdDataReady, frameError, parityError, busy
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// UART receive front end: 2-flop synchroniser, 16x oversampling, 3-sample majority vote per bit.
// Optional parity bit checking is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_sampler #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 9600,
    parameter int PARITY_ODD = 0
) (
    input logic               clk,
    input logic               reset,
    uart_rx_sampler_if.master bus
);
    localparam int DIV = CLK_FREQ / (BAUD * 16);
    localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);

    generate
        if (DIV < 2) begin : gDivCheck
            $error("uart_rx_sampler: CLK_FREQ/(BAUD*16) must be at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP, BRK
`ifdef UART_RX_PARITY_EN
        , PARITY
`endif
    } stateT;

    stateT         state;
    logic          rxdMeta, rxdSync;
    logic [CW-1:0] divCnt;
    logic          tick;
    logic [3:0]    sc;
    logic [2:0]    bitIdx;
    logic          s7, s8;
    logic          maj;
    logic [7:0]    shiftReg;
    logic [7:0]    dataReg;
    logic          readyReg, frameReg, parityReg;

`ifdef UART_RX_PARITY_EN
    logic parityBit;
    logic parityOk;
    assign parityOk = (((^shiftReg) ^ parityBit) == PARITY_ODD[0]);
`else
    logic unusedParityOdd;
    assign unusedParityOdd = PARITY_ODD[0];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rxdMeta <= 1'b1;
            rxdSync <= 1'b1;
        end else begin
            rxdMeta <= bus.rxd;
            rxdSync <= rxdMeta;
        end
    end

    // Free-running divider: one tick per 1/16 of a bit period.
    always_ff @(posedge clk) begin
        if (reset || divCnt == CW'(DIV - 1))
            divCnt <= '0;
        else
            divCnt <= divCnt + CW'(1);
    end

    assign tick = (divCnt == CW'(DIV - 1));
    assign maj  = (s7 & s8) | (s7 & rxdSync) | (s8 & rxdSync);

    // The vote is taken at sc=9 from the samples held at 7 and 8 plus the live line.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sc        <= '0;
            bitIdx    <= '0;
            s7        <= 1'b1;
            s8        <= 1'b1;
            shiftReg  <= '0;
            dataReg   <= '0;
            readyReg  <= 1'b0;
            frameReg  <= 1'b0;
            parityReg <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parityBit <= 1'b0;
`endif
        end else begin
            readyReg  <= 1'b0;
            frameReg  <= 1'b0;
            parityReg <= 1'b0;
            if (state == BRK) begin
                if (rxdSync)
                    state <= IDLE;
            end else if (tick) begin
                if (state == IDLE) begin
                    if (!rxdSync) begin
                        state <= START;
                        sc    <= '0;
                    end
                end else begin
                    sc <= sc + 4'd1;
                    if (sc == 4'd7)
                        s7 <= rxdSync;
                    if (sc == 4'd8)
                        s8 <= rxdSync;
                    case (state)
                        START: begin
                            if (sc == 4'd9 && maj) begin
                                state <= IDLE;
                            end else if (sc == 4'd15) begin
                                state  <= DATA;
                                bitIdx <= '0;
                            end
                        end
                        DATA: begin
                            if (sc == 4'd9)
                                shiftReg <= {maj, shiftReg[7:1]};
                            if (sc == 4'd15) begin
                                bitIdx <= bitIdx + 3'd1;
                                if (bitIdx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                    state <= PARITY;
`else
                                    state <= STOP;
`endif
                                end
                            end
                        end
`ifdef UART_RX_PARITY_EN
                        PARITY: begin
                            if (sc == 4'd9)
                                parityBit <= maj;
                            if (sc == 4'd15)
                                state <= STOP;
                        end
`endif
                        // Leave at mid-stop-bit so a following start bit is never missed.
                        STOP: begin
                            if (sc == 4'd9) begin
                                if (!maj) begin
                                    frameReg <= 1'b1;
                                    state    <= BRK;
`ifdef UART_RX_PARITY_EN
                                end else if (!parityOk) begin
                                    parityReg <= 1'b1;
                                    state     <= IDLE;
`endif
                                end else begin
                                    dataReg  <= shiftReg;
                                    readyReg <= 1'b1;
                                    state    <= IDLE;
                                end
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

    assign bus.data         = dataReg;
    assign bus.rxdDataReady = readyReg;
    assign bus.frameError   = frameReg;
    assign bus.parityError  = parityReg;
    assign bus.busy         = (state != IDLE);
endmodule

// File: tb/tb_uart_rx_sampler.sv
// Scoreboard bench for uart_rx_sampler: directed frames push expected events, a monitor checks them.
module tb_uart_rx_sampler;
    localparam int BAUD     = 9600;
    localparam int DIV      = 4;
    localparam int CLK_FREQ = BAUD * 16 * DIV;
    localparam int BIT_CLKS = 16 * DIV;
`ifdef UART_RX_PARITY_EN
    localparam int READY_TICKS = 170;
`else
    localparam int READY_TICKS = 154;
`endif
    localparam int EV_NONE   = -1;
    localparam int EV_READY  = 0;
    localparam int EV_FRAME  = 1;
    localparam int EV_PARITY = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         earliest;
        int         latest;
    } expT;

    expT        expQ[$];
    logic       clk = 1'b0;
    logic       reset;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    int         busySeen = 0;
    logic [7:0] heldData = 8'h00;

    uart_rx_sampler_if bus();

    uart_rx_sampler #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD(BAUD),
        .PARITY_ODD(0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int required);
        total++;
        if (actual != required) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, required);
        end
    endtask

    task automatic driveLine(input logic v, input int clocks);
        bus.rxd = v;
        repeat (clocks) @(posedge clk);
    endtask

    // One frame: start, 8 data bits LSB first, optional parity, stop; queues the expected event.
    task automatic applyStimulus(input logic [7:0] d, input logic par, input logic stopBit,
                                 input int expKind);
        expT e;
        if (expKind != EV_NONE) begin
            e.kind     = expKind;
            e.data     = (expKind == EV_READY) ? d : heldData;
            e.earliest = cyc + READY_TICKS * DIV - 4;
            e.latest   = cyc + READY_TICKS * DIV + 14;
            expQ.push_back(e);
            if (expKind == EV_READY)
                heldData = d;
        end
        driveLine(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++)
            driveLine(d[i], BIT_CLKS);
`ifdef UART_RX_PARITY_EN
        driveLine(par, BIT_CLKS);
`else
        if (par) begin
        end
`endif
        driveLine(stopBit, BIT_CLKS);
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (bus.busy)
                busySeen++;
            if (bus.rxdDataReady || bus.frameError || bus.parityError) begin
                int  kind;
                expT e;
                kind = bus.rxdDataReady ? EV_READY : (bus.frameError ? EV_FRAME : EV_PARITY);
                checkOutput("oneHotPulse",
                            int'(bus.rxdDataReady) + int'(bus.frameError) + int'(bus.parityError), 1);
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedEvent", kind, EV_NONE);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("eventKind", kind, e.kind);
                    checkOutput("eventData", int'(bus.data), int'(e.data));
                    checkOutput("eventLatencyInWindow",
                                int'(cyc >= e.earliest && cyc <= e.latest), 1);
                end
            end
        end
    end

    initial begin
        bus.rxd = 1'b1;
        reset   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("resetData", int'(bus.data), 0);
        checkOutput("resetReady", int'(bus.rxdDataReady), 0);
        checkOutput("resetFrameErr", int'(bus.frameError), 0);
        checkOutput("resetParityErr", int'(bus.parityError), 0);
        checkOutput("resetBusy", int'(bus.busy), 0);
        @(posedge clk);
        reset = 1'b0;
        driveLine(1'b1, BIT_CLKS);

        applyStimulus(8'h35, ^8'h35, 1'b1, EV_READY);
        driveLine(1'b1, BIT_CLKS);

        applyStimulus(8'h31, ^8'h31, 1'b1, EV_READY);
        applyStimulus(8'h32, ^8'h32, 1'b1, EV_READY);
        driveLine(1'b1, BIT_CLKS);

        // Short low pulse must be rejected as a false start.
        busySeen = 0;
        driveLine(1'b0, 4 * DIV);
        driveLine(1'b1, 2 * BIT_CLKS);
        @(negedge clk);
        checkOutput("glitchBusySeen", int'(busySeen > 0), 1);
        checkOutput("glitchBusyCleared", int'(bus.busy), 0);
        checkOutput("glitchDataHeld", int'(bus.data), int'(heldData));

        applyStimulus(8'h41, ^8'h41, 1'b0, EV_FRAME);
        driveLine(1'b0, 3 * BIT_CLKS);
        @(negedge clk);
        checkOutput("breakBusy", int'(bus.busy), 1);
        driveLine(1'b1, 2 * BIT_CLKS);
        applyStimulus(8'h42, ^8'h42, 1'b1, EV_READY);
        driveLine(1'b1, BIT_CLKS);

        // Reset during data bit 4 of 0x7E.
        driveLine(1'b0, BIT_CLKS);
        driveLine(1'b0, BIT_CLKS);
        for (int i = 1; i < 4; i++)
            driveLine(1'b1, BIT_CLKS);
        driveLine(1'b1, BIT_CLKS / 2);
        @(negedge clk);
        checkOutput("midFrameBusy", int'(bus.busy), 1);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        heldData = 8'h00;
        checkOutput("midResetData", int'(bus.data), 0);
        checkOutput("midResetBusy", int'(bus.busy), 0);
        checkOutput("midResetReady", int'(bus.rxdDataReady), 0);
        @(posedge clk);
        reset = 1'b0;
        driveLine(1'b1, 2 * BIT_CLKS);
        applyStimulus(8'h39, ^8'h39, 1'b1, EV_READY);
        driveLine(1'b1, BIT_CLKS);

`ifdef UART_RX_PARITY_EN
        applyStimulus(8'h33, 1'b1, 1'b1, EV_PARITY);
        driveLine(1'b1, BIT_CLKS);
        applyStimulus(8'h33, 1'b0, 1'b1, EV_READY);
        driveLine(1'b1, BIT_CLKS);
`endif

        driveLine(1'b1, 2 * BIT_CLKS);
        @(negedge clk);
        checkOutput("finalDataHeld", int'(bus.data), int'(heldData));
        checkOutput("pendingEvents", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_sampler.md
# uart_rx_sampler

UART receive front end that turns the asynchronous `rxd` line into validated 8-bit bytes for the calculator's input buffer. It sits directly upstream of the digit buffer/transmit stage and drives that stage's byte and ready inputs.

The block does the following:
- Synchronises `rxd` into the clock domain.
- Oversamples the line 16x.
- Majority-votes each bit.
- Rejects false start bits.
- Flags framing errors.

## Interface
Parameters:
- `CLK_FREQ`, default 50000000: system clock frequency in Hz.
- `BAUD`, default 9600: line rate in bits per second.
- `PARITY_ODD`, default 0: selects parity sense. 0 = even, 1 = odd. Only used with `UART_RX_PARITY_EN`.

Ports:
- `clk`, input, 1 bit: system clock. One clock; everything in the block is clocked on its rising edge.
- `reset`, input, 1 bit: reset is synchronous and active-high.
- `rxd`, input, 1 bit: asynchronous serial line. Idles high.
- `data`, output, 8 bits: last correctly received byte.
- `rxdDataReady`, output, 1 bit: one-cycle pulse when `data` has just been updated.
- `frameError`, output, 1 bit: one-cycle pulse when the stop bit is sampled low.
- `parityError`, output, 1 bit: one-cycle pulse on a parity mismatch.
- `busy`, output, 1 bit: high whenever the state machine is not in IDLE.

## Operation
- Synchroniser:
  - Two flops on `rxd`, both reset to 1.
  - All logic below uses the synchronised value.
- Tick generator:
  - Divisor is `DIV = CLK_FREQ / (BAUD*16)`, using integer truncation (325 at the defaults).
  - `DIV` must be at least 2.
  - Counter width is `clog2(DIV)`.
  - The counter is free-running; `tick` is high for one cycle each time the count reaches `DIV-1`.
- Sample counter `sc` (0..15):
  - Advances only on `tick`.
  - Samples are taken at `sc` = 7, 8 and 9.
  - The bit value is the majority of those 3 samples.
- States and transitions:
  - IDLE: on `tick` with the line at 0, go to START and set `sc` to 0.
  - START: at `sc`=9, evaluate the majority.
    - Majority 1 (glitch): return to IDLE; no outputs change.
    - Majority 0: continue until `sc`=15, then go to DATA with bit index 0.
  - DATA:
    - Each bit takes 16 ticks and is shifted in LSB first.
    - After bit 7 at `sc`=15, go to PARITY when enabled, otherwise to STOP.
  - PARITY: at `sc`=9, record the parity bit; at `sc`=15, go to STOP.
  - STOP: evaluate at `sc`=9, then always exit immediately. There is no wait for the end of the stop bit, so back-to-back frames are supported.
    - Majority 1 and parity good (or parity disabled): load `data` from the shift register, pulse `rxdDataReady`, go to IDLE.
    - Majority 1 and parity bad: pulse `parityError`; `data` is unchanged; go to IDLE.
    - Majority 0: pulse `frameError`; `data` is unchanged; go to BREAK.
  - BREAK: wait for a synchronised 1 on the line, then go to IDLE. A line held low therefore yields exactly one `frameError`.
- Simultaneous events: at most one of `rxdDataReady`, `frameError` and `parityError` is high in any cycle.

## Timing
- Reset values:
  - `data` = 0x00.
  - `rxdDataReady`, `frameError`, `parityError` and `busy` = 0.
  - State = IDLE; `sc`, bit index and tick counter = 0; synchroniser = 1.
- Reset asserted mid-frame aborts the frame on the next edge. No pulse is emitted, and `data` returns to 0.
- Start detection: `busy` rises 2–3 clocks plus up to `DIV` clocks after the falling edge of `rxd`.
- Ready latency, counted in ticks after the start-detect tick:
  - `rxdDataReady` asserts 16*9+10 = 154 ticks later with parity off.
  - It asserts 170 ticks later with parity on.
  - Tolerance is ±1 tick because the tick counter runs free.
- `data` is valid in the same cycle `rxdDataReady` is high and holds until the next good byte.
- Consumers must treat the ready pulse as an event; it is never held high.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The PARITY state is compiled in and frames carry a 9th bit.
  - Parity is checked against `PARITY_ODD`.
  - `parityError` is driven as described under Operation.
- `UART_RX_PARITY_EN` not defined:
  - The PARITY state is absent and frames are 8N1.
  - `parityError` is tied to 0.

## Test plan
- Byte 0x35 in 8N1 at 9600 baud with 50 MHz clock -> one `rxdDataReady` pulse with `data`=0x35 within 154±1 ticks of start; `frameError`=0.
- Back-to-back frames 0x31, 0x32 with a single stop bit between them -> two ready pulses, `data`=0x31 then 0x32; no error pulses.
- `rxd` low for 4 ticks only (glitch) -> `busy` pulses briefly; no ready or error pulse; `data` is unchanged.
- Frame 0x41 with stop bit low, line then held low for 3 bit times -> exactly one `frameError` pulse; `data` keeps its previous value; the next valid 0x42 is received correctly after the line returns high.
- `reset` asserted during data bit 4 of 0x7E -> all outputs return to reset values; no pulse; a following 0x39 is received correctly.
- With `UART_RX_PARITY_EN` and `PARITY_ODD`=0, send 0x33 with parity bit 1 -> `parityError` pulse, no ready. Send 0x33 with parity bit 0 -> ready pulse with `data`=0x33.
